// File: rtl/dac_spi_sequencer.sv
// Serialises one offset-binary sample per frame into a 16-bit SPI word for a 12-bit DAC.
// Frame layout: {2'b00, pd[1:0], sample left-justified in 12 bits}, MSB first, sampled on sclk falling edge.
module dac_spi_sequencer #(
    parameter int DATA_W   = 8,
    parameter int CLK_DIV  = 4,
    parameter int HOLD_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_pd,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cs_n,
    output logic              sclk,
    output logic              sdata,
    output logic              frame_done,
    output logic              busy
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HOLD_W = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CYC >= 2) ? HOLD_CYC - 2 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [3:0]          bit_q, bit_d;
    logic [15:0]         shreg_q, shreg_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic                sdata_q, sdata_d;
    logic                frame_done_q, frame_done_d;
    logic                in_ready_q, in_ready_d;
    logic [11:0]         field;
    logic [15:0]         word;

    always_comb begin
        field = 12'(in_data) << (12 - DATA_W);
        word  = {2'b00, in_pd, field};
    end

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        hold_d       = hold_q;
        cs_n_d       = cs_n_q;
        sclk_d       = sclk_q;
        sdata_d      = sdata_q;
        in_ready_d   = in_ready_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                cs_n_d     = 1'b1;
                sclk_d     = 1'b1;
                sdata_d    = 1'b0;
                if (in_valid && in_ready_q) begin
                    state_d    = SHIFT;
                    in_ready_d = 1'b0;
                    cs_n_d     = 1'b0;
                    shreg_d    = word;
                    sdata_d    = word[15];
                    div_d      = '0;
                    bit_d      = 4'd15;
                end
            end
            SHIFT: begin
                in_ready_d = 1'b0;
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else if (bit_q == 4'd0) begin
                        cs_n_d  = 1'b1;
                        sclk_d  = 1'b1;
                        sdata_d = 1'b0;
                        hold_d  = '0;
                        // The frame_done/IDLE cycle is the last cs_n-high cycle, so HOLD
                        // itself spans HOLD_CYC-1 cycles and vanishes when HOLD_CYC is 1.
                        if (HOLD_CYC > 1) begin
                            state_d = HOLD;
                        end else begin
                            state_d      = IDLE;
                            in_ready_d   = 1'b1;
                            frame_done_d = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q - 4'd1;
                        sclk_d  = 1'b1;
                        shreg_d = {shreg_q[14:0], 1'b0};
                        sdata_d = shreg_q[14];
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            HOLD: begin
                in_ready_d = 1'b0;
                if (hold_q == HOLD_LAST) begin
                    state_d      = IDLE;
                    in_ready_d   = 1'b1;
                    frame_done_d = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                cs_n_d     = 1'b1;
                sclk_d     = 1'b1;
                sdata_d    = 1'b0;
                in_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            div_q        <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            hold_q       <= '0;
            cs_n_q       <= 1'b1;
            sclk_q       <= 1'b1;
            sdata_q      <= 1'b0;
            frame_done_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            hold_q       <= hold_d;
            cs_n_q       <= cs_n_d;
            sclk_q       <= sclk_d;
            sdata_q      <= sdata_d;
            frame_done_q <= frame_done_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign cs_n       = cs_n_q;
    assign sclk       = sclk_q;
    assign sdata      = sdata_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);

endmodule
